// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared constants and types for the multi-channel score counter
// Contents:
//   SCORE_MODE_SAT / SCORE_MODE_WRAP  values of wrap_i
//   SCORE_MAX_CHANNELS                largest supported channel count
//   SCORE_LEADER_W                    width of the leader index output
//   score_act_e                       per-channel action chosen each cycle
package score_pkg;

  localparam logic SCORE_MODE_SAT  = 1'b0;
  localparam logic SCORE_MODE_WRAP = 1'b1;

  localparam int SCORE_MAX_CHANNELS = 8;
  localparam int SCORE_LEADER_W     = 3;

  typedef enum logic [2:0] {
    SCORE_ACT_HOLD,
    SCORE_ACT_CLR,
    SCORE_ACT_LOAD,
    SCORE_ACT_UP,
    SCORE_ACT_DN
  } score_act_e;

endpackage

// File: rtl/score_channel.sv
// rtl/score_channel.sv - one bounded up/down counter with edge detect and limit flag
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   inc_i, dec_i        count-up / count-down request levels (edge detected here)
//   wrap_i              1: wrap at limits, 0: saturate
//   step_i              step per event, 0 behaves as 1
//   clr_i, load_i       synchronous clear / load (clear wins)
//   load_val_i          load value, clipped to MAX_VAL
//   cnt_o               registered count
//   lim_o               registered one-cycle pulse when an event wrapped or clipped
module score_channel
  import score_pkg::*;
#(
  parameter int BW      = 7,
  parameter int MAX_VAL = 99,
  parameter int SW      = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc_i,
  input  logic          dec_i,
  input  logic          wrap_i,
  input  logic [SW-1:0] step_i,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic [BW-1:0] load_val_i,
  output logic [BW-1:0] cnt_o,
  output logic          lim_o
);

  // Wide enough for cnt + step and cnt + MAX_VAL + 1 without overflow.
  localparam int AW = ((BW > SW) ? BW : SW) + 1;
  localparam logic [AW-1:0] MAX_A = AW'(MAX_VAL);
  localparam logic [AW-1:0] MOD_A = AW'(MAX_VAL + 1);

  logic          inc_q, dec_q;
  logic [BW-1:0] cnt_q, cnt_d;
  logic          lim_q, lim_d;
  logic          up_ev, dn_ev;
  score_act_e    act;
  logic [AW-1:0] cnt_a, s_raw, s_eff, sum_a, load_a;

  assign up_ev = inc_i & ~inc_q;
  assign dn_ev = dec_i & ~dec_q;

  always_comb begin
    if (clr_i)                    act = SCORE_ACT_CLR;
    else if (load_i)              act = SCORE_ACT_LOAD;
    else if (up_ev && !dn_ev)     act = SCORE_ACT_UP;
    else if (dn_ev && !up_ev)     act = SCORE_ACT_DN;
    else                          act = SCORE_ACT_HOLD;
  end

  assign cnt_a  = AW'(cnt_q);
  assign load_a = AW'(load_val_i);
  assign s_raw  = (step_i == '0) ? AW'(1) : AW'(step_i);
  // In wrap mode a step larger than the range is folded first, so one wrap per event suffices.
  assign s_eff  = (wrap_i == SCORE_MODE_WRAP) ? (s_raw % MOD_A) : s_raw;
  assign sum_a  = cnt_a + s_eff;

  always_comb begin
    cnt_d = cnt_q;
    lim_d = 1'b0;
    case (act)
      SCORE_ACT_CLR:  cnt_d = '0;
      SCORE_ACT_LOAD: cnt_d = (load_a > MAX_A) ? BW'(MAX_VAL) : load_val_i;
      SCORE_ACT_UP: begin
        if (wrap_i == SCORE_MODE_WRAP) begin
          if (sum_a > MAX_A) begin
            cnt_d = BW'(sum_a - MOD_A);
            lim_d = 1'b1;
          end else begin
            cnt_d = BW'(sum_a);
          end
        end else if (sum_a >= MAX_A) begin
          // Hitting MAX_VAL exactly and a blocked attempt at MAX_VAL both flag.
          cnt_d = BW'(MAX_VAL);
          lim_d = 1'b1;
        end else begin
          cnt_d = BW'(sum_a);
        end
      end
      SCORE_ACT_DN: begin
        if (wrap_i == SCORE_MODE_WRAP) begin
          if (cnt_a < s_eff) begin
            cnt_d = BW'(cnt_a + MOD_A - s_eff);
            lim_d = 1'b1;
          end else begin
            cnt_d = BW'(cnt_a - s_eff);
          end
        end else if (cnt_a <= s_eff) begin
          cnt_d = '0;
          lim_d = 1'b1;
        end else begin
          cnt_d = BW'(cnt_a - s_eff);
        end
      end
      default: ;
    endcase
  end

  // Edge registers reset high so a request held through reset is not an event.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inc_q <= 1'b1;
      dec_q <= 1'b1;
      cnt_q <= '0;
      lim_q <= 1'b0;
    end else begin
      inc_q <= inc_i;
      dec_q <= dec_i;
      cnt_q <= cnt_d;
      lim_q <= lim_d;
    end
  end

  assign cnt_o = cnt_q;
  assign lim_o = lim_q;

endmodule

// File: rtl/score_counter_array.sv
// rtl/score_counter_array.sv - CHANNELS independent score counters plus leader/tie detection
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   inc_i, dec_i          per-channel count requests (levels)
//   wrap_i, step_i        shared wrap/saturate mode and step
//   clr_i, load_i         per-channel clear / load
//   load_val_i            shared load value
//   cnt_o                 channel c at [c*BW +: BW]
//   at_max_o, at_min_o    per-channel limit status from registered counts
//   lim_o                 per-channel limit event pulse
//   leader_o, tie_o       highest channel (lowest index on tie) and shared-maximum flag
module score_counter_array
  import score_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int BW       = 7,
  parameter int MAX_VAL  = 99,
  parameter int SW       = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [CHANNELS-1:0]       inc_i,
  input  logic [CHANNELS-1:0]       dec_i,
  input  logic                      wrap_i,
  input  logic [SW-1:0]             step_i,
  input  logic [CHANNELS-1:0]       clr_i,
  input  logic [CHANNELS-1:0]       load_i,
  input  logic [BW-1:0]             load_val_i,
  output logic [CHANNELS*BW-1:0]    cnt_o,
  output logic [CHANNELS-1:0]       at_max_o,
  output logic [CHANNELS-1:0]       at_min_o,
  output logic [CHANNELS-1:0]       lim_o,
  output logic [SCORE_LEADER_W-1:0] leader_o,
  output logic                      tie_o
);

  if (MAX_VAL >= (1 << BW)) begin : g_bad_max
    $error("score_counter_array: MAX_VAL does not fit in BW bits");
  end
  if (CHANNELS < 1 || CHANNELS > SCORE_MAX_CHANNELS) begin : g_bad_ch
    $error("score_counter_array: CHANNELS out of range");
  end

  logic [BW-1:0] cnt_arr [CHANNELS];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    score_channel #(
      .BW      (BW),
      .MAX_VAL (MAX_VAL),
      .SW      (SW)
    ) u_ch (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .inc_i      (inc_i[c]),
      .dec_i      (dec_i[c]),
      .wrap_i     (wrap_i),
      .step_i     (step_i),
      .clr_i      (clr_i[c]),
      .load_i     (load_i[c]),
      .load_val_i (load_val_i),
      .cnt_o      (cnt_arr[c]),
      .lim_o      (lim_o[c])
    );
    assign cnt_o[c*BW +: BW] = cnt_arr[c];
    assign at_max_o[c]       = (cnt_arr[c] == BW'(MAX_VAL));
    assign at_min_o[c]       = (cnt_arr[c] == '0);
  end

  logic [BW-1:0]             best_val;
  logic [SCORE_LEADER_W-1:0] best_idx;
  logic                      best_tie;

  // Strict '>' keeps the lowest index; best_tie tracks whether the current best is shared.
  always_comb begin
    best_val = cnt_arr[0];
    best_idx = '0;
    best_tie = 1'b0;
    for (int c = 1; c < CHANNELS; c++) begin
      if (cnt_arr[c] > best_val) begin
        best_val = cnt_arr[c];
        best_idx = SCORE_LEADER_W'(c);
        best_tie = 1'b0;
      end else if (cnt_arr[c] == best_val) begin
        best_tie = 1'b1;
      end
    end
  end

  assign leader_o = best_idx;
  assign tie_o    = best_tie;

endmodule
